// File: rtl/alu_reservation_station_pkg.sv
// Shared types for the ALU reservation station: the ALU control op encoding,
// per-slot operand/entry records, and the CDB capture rule used by dispatch and wakeup.
package alu_reservation_station_pkg;

  localparam int RS_TAG_W = 4;
  localparam int RS_XLEN  = 32;

  typedef enum logic [3:0] {
    noALU   = 4'd0,
    addALU  = 4'd1,
    subALU  = 4'd2,
    andALU  = 4'd3,
    orALU   = 4'd4,
    xorALU  = 4'd5,
    sllALU  = 4'd6,
    srlALU  = 4'd7,
    sraALU  = 4'd8,
    sltALU  = 4'd9,
    sltuALU = 4'd10,
    luiALU  = 4'd11
  } ALU_operation_t;

  typedef struct packed {
    logic                rdy;
    logic [RS_TAG_W-1:0] tag;
    logic [RS_XLEN-1:0]  val;
  } rs_operand_t;

  typedef struct packed {
    ALU_operation_t      op;
    logic [RS_TAG_W-1:0] rob_tag;
    rs_operand_t         src1;
    rs_operand_t         src2;
  } rs_entry_t;

  // A pending operand whose producer tag is on the CDB takes the broadcast value.
  function automatic rs_operand_t rs_capture(
    input logic                rdy,
    input logic [RS_TAG_W-1:0] tag,
    input logic [RS_XLEN-1:0]  val,
    input logic                cdb_valid,
    input logic [RS_TAG_W-1:0] cdb_tag,
    input logic [RS_XLEN-1:0]  cdb_value
  );
    rs_operand_t o;
    o.rdy = rdy;
    o.tag = tag;
    o.val = val;
    if (!rdy && cdb_valid && (tag == cdb_tag)) begin
      o.rdy = 1'b1;
      o.val = cdb_value;
    end
    return o;
  endfunction

endpackage

// File: rtl/alu_reservation_station_rs_priority_encoder.sv
// Lowest-set-bit priority encoder: index of the first asserted request plus an any flag.
module rs_priority_encoder #(
  parameter int WIDTH = 4,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scanning downward lets the lowest set bit win.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/alu_reservation_station.sv
// Reservation station for integer ALU micro-ops: holds dispatched ops, wakes pending
// operands from the CDB, and issues the lowest-index operand-complete op each cycle.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int TAG_W   = RS_TAG_W,
  parameter int XLEN    = RS_XLEN
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         dispatch_valid,
  output logic                         dispatch_ready,
  input  ALU_operation_t               dispatch_op,
  input  logic [TAG_W-1:0]             dispatch_rob_tag,
  input  logic                         dispatch_src1_rdy,
  input  logic                         dispatch_src2_rdy,
  input  logic [TAG_W-1:0]             dispatch_src1_tag,
  input  logic [TAG_W-1:0]             dispatch_src2_tag,
  input  logic [XLEN-1:0]              dispatch_src1_val,
  input  logic [XLEN-1:0]              dispatch_src2_val,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [XLEN-1:0]              cdb_value,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output ALU_operation_t               issue_op,
  output logic [XLEN-1:0]              issue_a,
  output logic [XLEN-1:0]              issue_b,
  output logic [TAG_W-1:0]             issue_rob_tag,
  output logic [$clog2(ENTRIES):0]     free_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(ENTRIES) + 1;

  // Entry records are packed structs sized by the package widths.
  if ((TAG_W != RS_TAG_W) || (XLEN != RS_XLEN)) begin : g_width_check
    $error("alu_reservation_station: TAG_W/XLEN must match package widths");
  end

  logic [ENTRIES-1:0] valid_q;
  rs_entry_t          entry_q [ENTRIES];
  logic [ENTRIES-1:0] eligible;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               free_any;
  logic               sel_any;
  logic               dispatch_fire;
  logic               issue_fire;
  rs_entry_t          sel_entry;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      eligible[i] = valid_q[i] & entry_q[i].src1.rdy & entry_q[i].src2.rdy;
    end
  end

  rs_priority_encoder #(.WIDTH(ENTRIES), .IDX_W(IDX_W)) u_free_enc (
    .req (~valid_q),
    .idx (free_idx),
    .any (free_any)
  );

  rs_priority_encoder #(.WIDTH(ENTRIES), .IDX_W(IDX_W)) u_sel_enc (
    .req (eligible),
    .idx (sel_idx),
    .any (sel_any)
  );

  // Dispatch side sees only registered occupancy, so no issue_ready path reaches it.
  assign dispatch_ready = free_any;
  assign dispatch_fire  = dispatch_valid & free_any;
  assign issue_valid    = sel_any & ~flush;
  assign issue_fire     = issue_valid & issue_ready;

  always_comb begin
    free_count = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      free_count = free_count + {{(CNT_W-1){1'b0}}, ~valid_q[i]};
    end
  end

  always_comb begin
    sel_entry     = entry_q[sel_idx];
    issue_op      = noALU;
    issue_a       = '0;
    issue_b       = '0;
    issue_rob_tag = '0;
    if (issue_valid) begin
      issue_op      = sel_entry.op;
      issue_a       = sel_entry.src1.val;
      issue_b       = sel_entry.src2.val;
      issue_rob_tag = sel_entry.rob_tag;
    end
  end

  // Occupancy: flush dominates; issued and dispatched slots are always distinct.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (issue_fire && (sel_idx == IDX_W'(i))) valid_q[i] <= 1'b0;
        if (dispatch_fire && (free_idx == IDX_W'(i))) valid_q[i] <= 1'b1;
      end
    end
  end

  // Payload is only meaningful under valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (dispatch_fire && (free_idx == IDX_W'(i))) begin
        entry_q[i].op      <= dispatch_op;
        entry_q[i].rob_tag <= dispatch_rob_tag;
        entry_q[i].src1    <= rs_capture(dispatch_src1_rdy, dispatch_src1_tag, dispatch_src1_val,
                                         cdb_valid, cdb_tag, cdb_value);
        entry_q[i].src2    <= rs_capture(dispatch_src2_rdy, dispatch_src2_tag, dispatch_src2_val,
                                         cdb_valid, cdb_tag, cdb_value);
      end else if (valid_q[i]) begin
        entry_q[i].src1 <= rs_capture(entry_q[i].src1.rdy, entry_q[i].src1.tag, entry_q[i].src1.val,
                                      cdb_valid, cdb_tag, cdb_value);
        entry_q[i].src2 <= rs_capture(entry_q[i].src2.rdy, entry_q[i].src2.tag, entry_q[i].src2.val,
                                      cdb_valid, cdb_tag, cdb_value);
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Scoreboard bench for alu_reservation_station: directed dispatch/wakeup/flush/reset vectors.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic           dispatch_valid;
  logic           dispatch_ready;
  ALU_operation_t dispatch_op;
  logic [3:0]     dispatch_rob_tag;
  logic           dispatch_src1_rdy, dispatch_src2_rdy;
  logic [3:0]     dispatch_src1_tag, dispatch_src2_tag;
  logic [31:0]    dispatch_src1_val, dispatch_src2_val;
  logic           cdb_valid;
  logic [3:0]     cdb_tag;
  logic [31:0]    cdb_value;
  logic           issue_valid;
  logic           issue_ready;
  ALU_operation_t issue_op;
  logic [31:0]    issue_a, issue_b;
  logic [3:0]     issue_rob_tag;
  logic [2:0]     free_count;

  typedef struct packed {
    ALU_operation_t op;
    logic [31:0]    a;
    logic [31:0]    b;
    logic [3:0]     tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  alu_reservation_station dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .dispatch_valid    (dispatch_valid),
    .dispatch_ready    (dispatch_ready),
    .dispatch_op       (dispatch_op),
    .dispatch_rob_tag  (dispatch_rob_tag),
    .dispatch_src1_rdy (dispatch_src1_rdy),
    .dispatch_src2_rdy (dispatch_src2_rdy),
    .dispatch_src1_tag (dispatch_src1_tag),
    .dispatch_src2_tag (dispatch_src2_tag),
    .dispatch_src1_val (dispatch_src1_val),
    .dispatch_src2_val (dispatch_src2_val),
    .cdb_valid         (cdb_valid),
    .cdb_tag           (cdb_tag),
    .cdb_value         (cdb_value),
    .issue_valid       (issue_valid),
    .issue_ready       (issue_ready),
    .issue_op          (issue_op),
    .issue_a           (issue_a),
    .issue_b           (issue_b),
    .issue_rob_tag     (issue_rob_tag),
    .free_count        (free_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change only just after a rising edge; probes land just after the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    #5;
  endtask

  task automatic set_dispatch(input ALU_operation_t op, input logic [3:0] rob,
                              input logic r1, input logic [3:0] t1, input logic [31:0] v1,
                              input logic r2, input logic [3:0] t2, input logic [31:0] v2);
    dispatch_valid    = 1'b1;
    dispatch_op       = op;
    dispatch_rob_tag  = rob;
    dispatch_src1_rdy = r1;
    dispatch_src1_tag = t1;
    dispatch_src1_val = v1;
    dispatch_src2_rdy = r2;
    dispatch_src2_tag = t2;
    dispatch_src2_val = v2;
  endtask

  task automatic dispatch_one(input ALU_operation_t op, input logic [3:0] rob,
                              input logic r1, input logic [3:0] t1, input logic [31:0] v1,
                              input logic r2, input logic [3:0] t2, input logic [31:0] v2);
    set_dispatch(op, rob, r1, t1, v1, r2, t2, v2);
    step();
    dispatch_valid = 1'b0;
  endtask

  task automatic push(input ALU_operation_t op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag);
    exp_t e;
    e.op  = op;
    e.a   = a;
    e.b   = b;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted issue must match the oldest expected record.
  always @(negedge clk) begin
    exp_t got;
    exp_t e;
    if (!rst && issue_valid && issue_ready) begin
      got.op  = issue_op;
      got.a   = issue_a;
      got.b   = issue_b;
      got.tag = issue_rob_tag;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL issue_unexpected: got %h expected no issue", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL issue_payload: got %h expected %h", got, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    dispatch_valid = 1'b0;
    dispatch_op = noALU;
    dispatch_rob_tag = '0;
    dispatch_src1_rdy = 1'b0;
    dispatch_src2_rdy = 1'b0;
    dispatch_src1_tag = '0;
    dispatch_src2_tag = '0;
    dispatch_src1_val = '0;
    dispatch_src2_val = '0;
    cdb_valid = 1'b0;
    cdb_tag = '0;
    cdb_value = '0;
    issue_ready = 1'b1;

    #3;
    check("rst_dispatch_ready", 32'(dispatch_ready), 32'd1);
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_free_count", 32'(free_count), 32'd4);
    check("rst_issue_op", 32'(issue_op), 32'(noALU));
    check("rst_issue_a", issue_a, 32'd0);
    check("rst_issue_b", issue_b, 32'd0);
    check("rst_issue_rob_tag", 32'(issue_rob_tag), 32'd0);
    step();
    rst = 1'b0;

    // Both operands ready: issues the cycle after dispatch.
    push(addALU, 32'd5, 32'd7, 4'd1);
    dispatch_one(addALU, 4'd1, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7);
    probe();
    check("t1_issue_valid", 32'(issue_valid), 32'd1);
    check("t1_free_count_busy", 32'(free_count), 32'd3);
    step();
    probe();
    check("t1_free_count_back", 32'(free_count), 32'd4);
    check("t1_issue_idle", 32'(issue_valid), 32'd0);

    // src1 waits on tag 3; wakeup makes it eligible one cycle after the broadcast edge.
    push(subALU, 32'd10, 32'd2, 4'd2);
    dispatch_one(subALU, 4'd2, 1'b0, 4'd3, 32'd0, 1'b1, 4'd0, 32'd2);
    probe();
    check("t2_wait0", 32'(issue_valid), 32'd0);
    step();
    probe();
    check("t2_wait1", 32'(issue_valid), 32'd0);
    step();
    cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_value = 32'd10;
    probe();
    check("t2_bcast_cycle", 32'(issue_valid), 32'd0);
    step();
    cdb_valid = 1'b0;
    probe();
    check("t2_woken", 32'(issue_valid), 32'd1);
    check("t2_issue_a", issue_a, 32'd10);
    step();
    probe();
    check("t2_free_count", 32'(free_count), 32'd4);

    // Dispatch bypass from a same-cycle broadcast.
    push(orALU, 32'h55, 32'd3, 4'd4);
    cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_value = 32'h55;
    dispatch_one(orALU, 4'd4, 1'b0, 4'd6, 32'd0, 1'b1, 4'd0, 32'd3);
    cdb_valid = 1'b0;
    probe();
    check("t3_bypass_issue", 32'(issue_valid), 32'd1);
    check("t3_bypass_a", issue_a, 32'h55);
    step();

    // Fill the station with waiting ops, then stall the ALU.
    issue_ready = 1'b0;
    dispatch_one(andALU, 4'd8,  1'b0, 4'd12, 32'd0, 1'b1, 4'd0, 32'h11);
    dispatch_one(xorALU, 4'd9,  1'b0, 4'd13, 32'd0, 1'b1, 4'd0, 32'h22);
    dispatch_one(luiALU, 4'd10, 1'b0, 4'd14, 32'd0, 1'b1, 4'd0, 32'h33);
    dispatch_one(noALU,  4'd11, 1'b0, 4'd15, 32'd0, 1'b1, 4'd0, 32'h44);
    probe();
    check("t4_full_ready", 32'(dispatch_ready), 32'd0);
    check("t4_full_count", 32'(free_count), 32'd0);
    step();
    set_dispatch(addALU, 4'd7, 1'b1, 4'd0, 32'hAA, 1'b1, 4'd0, 32'hBB);
    step();
    dispatch_valid = 1'b0;
    probe();
    check("t4_ignored_count", 32'(free_count), 32'd0);
    check("t4_ignored_issue", 32'(issue_valid), 32'd0);
    step();
    cdb_valid = 1'b1; cdb_tag = 4'd13; cdb_value = 32'h200;
    step();
    cdb_valid = 1'b1; cdb_tag = 4'd12; cdb_value = 32'h100;
    probe();
    check("t4_entry1_shown", 32'(issue_rob_tag), 32'd9);
    step();
    cdb_valid = 1'b0;
    probe();
    check("t4_entry0_shown", 32'(issue_rob_tag), 32'd8);
    check("t4_entry0_a", issue_a, 32'h100);
    step();
    push(andALU, 32'h100, 32'h11, 4'd8);
    push(xorALU, 32'h200, 32'h22, 4'd9);
    issue_ready = 1'b1;
    probe();
    check("t4_accept0", 32'(issue_rob_tag), 32'd8);
    step();
    probe();
    check("t4_accept1", 32'(issue_rob_tag), 32'd9);
    step();
    probe();
    check("t4_after_count", 32'(free_count), 32'd2);
    check("t4_after_issue", 32'(issue_valid), 32'd0);

    // Flush with three valid entries, one of them eligible.
    step();
    issue_ready = 1'b0;
    dispatch_one(luiALU, 4'd5, 1'b1, 4'd0, 32'h77, 1'b1, 4'd0, 32'd0);
    probe();
    check("t5_pre_issue", 32'(issue_valid), 32'd1);
    check("t5_pre_count", 32'(free_count), 32'd1);
    step();
    flush = 1'b1;
    issue_ready = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 4'd14; cdb_value = 32'h3C;
    set_dispatch(addALU, 4'd6, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1);
    probe();
    check("t5_flush_gates_issue", 32'(issue_valid), 32'd0);
    step();
    flush = 1'b0;
    cdb_valid = 1'b0;
    dispatch_valid = 1'b0;
    probe();
    check("t5_flushed_count", 32'(free_count), 32'd4);
    check("t5_flushed_issue", 32'(issue_valid), 32'd0);
    step();
    probe();
    check("t5_still_idle", 32'(issue_valid), 32'd0);

    // Asynchronous reset while a wakeup broadcast is in flight.
    step();
    issue_ready = 1'b0;
    dispatch_one(addALU, 4'd3,  1'b1, 4'd0, 32'h9, 1'b1, 4'd0, 32'h1);
    dispatch_one(subALU, 4'd12, 1'b0, 4'd2, 32'h0, 1'b1, 4'd0, 32'h4);
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_value = 32'h9;
    probe();
    check("t6_pre_rst_tag", 32'(issue_rob_tag), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_issue_valid", 32'(issue_valid), 32'd0);
    check("t6_rst_free_count", 32'(free_count), 32'd4);
    check("t6_rst_dispatch_ready", 32'(dispatch_ready), 32'd1);
    check("t6_rst_issue_op", 32'(issue_op), 32'(noALU));
    check("t6_rst_issue_a", issue_a, 32'd0);
    check("t6_rst_issue_rob_tag", 32'(issue_rob_tag), 32'd0);
    step();
    cdb_valid = 1'b0;
    step();
    rst = 1'b0;
    issue_ready = 1'b1;
    probe();
    check("t6_post_idle0", 32'(issue_valid), 32'd0);
    check("t6_post_count", 32'(free_count), 32'd4);
    step();
    probe();
    check("t6_post_idle1", 32'(issue_valid), 32'd0);

    step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
